// File: rtl/multdiv.sv
// Iterative signed 32x32 multiplier / divider: shift-add multiply, non-restoring divide, 32 steps each.
// Optional macro MULTDIV_EARLY_ZERO_EN: divide by zero completes right after the start edge.
module multdiv #(
  localparam int DATA_W = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] data_operandA,
  input  logic signed [DATA_W-1:0] data_operandB,
  input  logic                     ctrl_MULT,
  input  logic                     ctrl_DIV,
  output logic signed [DATA_W-1:0] data_result,
  output logic                     data_exception,
  output logic                     data_resultRDY
);

  typedef enum logic [1:0] {IDLE, MULT_RUN, DIV_RUN, DONE} state_t;

  state_t                state, next_state;
  logic [4:0]            cnt;
  logic [DATA_W+1:0]     hi;    // product high part, or signed partial remainder
  logic [DATA_W-1:0]     lo;    // multiplier being shifted out, or quotient being shifted in
  logic [DATA_W-1:0]     opnd;  // multiplicand or divisor magnitude
  logic                  neg, div_zero, div_ovf;

  logic                  start_mult, start_div, b_zero, last_step;
  logic [DATA_W:0]       mul_add;
  logic [2*DATA_W-1:0]   prod;
  logic signed [DATA_W+1:0] rem_sh, rem_nx;
  logic [DATA_W-1:0]     q_nx, q_fix;

  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v);
    return v[DATA_W-1] ? DATA_W'(-v) : v;
  endfunction

  function automatic logic [2*DATA_W-1:0] fix_sign64(input logic [2*DATA_W-1:0] m, input logic n);
    return n ? -m : m;
  endfunction

  function automatic logic mul_overflow(input logic [2*DATA_W-1:0] p);
    return p[2*DATA_W-1:DATA_W] != {DATA_W{p[DATA_W-1]}};
  endfunction

  always_comb begin
    start_mult = ctrl_MULT;
    start_div  = ctrl_DIV & ~ctrl_MULT;
    b_zero     = (data_operandB == '0);
    last_step  = (cnt == 5'd31);

    mul_add = hi[DATA_W:0] + (lo[0] ? {1'b0, opnd} : {(DATA_W+1){1'b0}});
    prod    = fix_sign64({mul_add, lo[DATA_W-1:1]}, neg);

    // Non-restoring step: subtract while the remainder is non-negative, add back otherwise.
    rem_sh = {hi[DATA_W:0], lo[DATA_W-1]};
    rem_nx = hi[DATA_W+1] ? rem_sh + $signed({2'b00, opnd}) : rem_sh - $signed({2'b00, opnd});
    q_nx   = {lo[DATA_W-2:0], ~rem_nx[DATA_W+1]};
    q_fix  = neg ? -q_nx : q_nx;
  end

  always_comb begin
    next_state = state;
    if (start_mult) begin
      next_state = MULT_RUN;
    end else if (start_div) begin
`ifdef MULTDIV_EARLY_ZERO_EN
      next_state = b_zero ? DONE : DIV_RUN;
`else
      next_state = DIV_RUN;
`endif
    end else begin
      case (state)
        MULT_RUN: if (last_step) next_state = DONE;
        DIV_RUN:  if (last_step) next_state = DONE;
        DONE:     next_state = IDLE;
        default:  next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt            <= '0;
      hi             <= '0;
      lo             <= '0;
      opnd           <= '0;
      neg            <= 1'b0;
      div_zero       <= 1'b0;
      div_ovf        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= (next_state == DONE);
      if (start_mult) begin
        cnt      <= '0;
        hi       <= '0;
        lo       <= mag(data_operandB);
        opnd     <= mag(data_operandA);
        neg      <= data_operandA[DATA_W-1] ^ data_operandB[DATA_W-1];
        div_zero <= 1'b0;
        div_ovf  <= 1'b0;
      end else if (start_div) begin
        cnt      <= '0;
        hi       <= '0;
        lo       <= mag(data_operandA);
        opnd     <= mag(data_operandB);
        neg      <= data_operandA[DATA_W-1] ^ data_operandB[DATA_W-1];
        div_zero <= b_zero;
        div_ovf  <= (data_operandA == {1'b1, {(DATA_W-1){1'b0}}}) && (data_operandB == '1);
`ifdef MULTDIV_EARLY_ZERO_EN
        if (b_zero) begin
          data_result    <= '0;
          data_exception <= 1'b1;
        end
`endif
      end else begin
        case (state)
          MULT_RUN: begin
            cnt <= cnt + 5'd1;
            hi  <= {2'b00, mul_add[DATA_W:1]};
            lo  <= {mul_add[0], lo[DATA_W-1:1]};
            if (last_step) begin
              data_result    <= prod[DATA_W-1:0];
              data_exception <= mul_overflow(prod);
            end
          end
          DIV_RUN: begin
            cnt <= cnt + 5'd1;
            hi  <= rem_nx;
            lo  <= q_nx;
            if (last_step) begin
              data_result    <= div_zero ? '0 : q_fix;
              data_exception <= div_zero | div_ovf;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/multdiv.md
MULTDIV -- requirements
Module: multdiv

Interface
REQ-001 SHALL: clock  input  1  single master clock; all state updates on rising edge.
REQ-002 SHALL: reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL: data_operandA  input  32  signed multiplicand / dividend.
REQ-004 SHALL: data_operandB  input  32  signed multiplier / divisor.
REQ-005 SHALL: ctrl_MULT  input  1  one-cycle start pulse for signed multiply.
REQ-006 SHALL: ctrl_DIV  input  1  one-cycle start pulse for signed divide.
REQ-007 SHALL: data_result  output  32  product low word or quotient, registered.
REQ-008 SHALL: data_exception  output  1  overflow or divide-by-zero flag, registered, valid with data_resultRDY.
REQ-009 SHALL: data_resultRDY  output  1  result-valid strobe, high exactly one cycle per operation.

Function
REQ-010 SHALL: states IDLE, MULT_RUN, DIV_RUN, DONE; reset state IDLE.
REQ-011 SHALL: operands are sampled only at the start edge (E0); later operand changes do not affect the operation.
REQ-012 SHALL: start accepted in any state; a start during MULT_RUN/DIV_RUN aborts the current operation and restarts it with the new operands; a start during DONE drops data_resultRDY on the next edge.
REQ-013 SHALL: ctrl_MULT and ctrl_DIV high together: multiply wins; divide ignored.
REQ-014 SHALL: multiply = radix-2 shift-add on magnitudes plus sign fix-up, one step per edge; 32 steps; 5-bit counter.
REQ-015 SHALL: divide = non-restoring on magnitudes, one quotient bit per edge; 32 steps; quotient truncates toward zero; quotient sign = XOR of operand signs.
REQ-016 SHALL: RUN -> DONE at the edge completing step 32 (E32); DONE -> IDLE at the next edge unless a start is present; data_resultRDY high only in DONE, i.e. the cycle after E32.
REQ-017 SHALL: data_result and data_exception hold their last values in IDLE and RUN; they change only on entry to DONE or on reset.
REQ-018 SHALL: multiply result = low 32 bits of the 64-bit signed product; exception = 1 when the upper 32 bits are not the sign extension of bit 31.
REQ-019 SHALL: divide by zero -> data_result 0, data_exception 1.
REQ-020 SHALL: 0x80000000 / 0xFFFFFFFF -> data_result 0x80000000, data_exception 1.
REQ-021 SHALL: all other divides -> data_exception 0.

Reset
REQ-022 SHALL: reset forces state IDLE, counter 0, data_result 0, data_exception 0, data_resultRDY 0, asynchronously and regardless of the clock.
REQ-023 SHALL: a reset asserted mid-operation discards that operation; no data_resultRDY is produced for it.
REQ-024 SHALL: the first start edge after reset release is accepted normally.

Configuration
REQ-025 SHALL: macro MULTDIV_EARLY_ZERO_EN, when defined, makes a divide with a zero divisor go from E0 directly to DONE; data_resultRDY is then high in the cycle after E0, with result 0 and exception 1.
REQ-026 SHALL: without MULTDIV_EARLY_ZERO_EN, a divide by zero runs the full 32 steps; data_resultRDY is high in the cycle after E32 with the same result and exception values.
REQ-027 SHALL: the macro does not change multiply behaviour or the latency of divides by nonzero divisors.

Verification
REQ-028 SHALL: MULT 7 x -6 -> in the cycle after E32: data_resultRDY=1, result 0xFFFFFFD6, exception 0; data_resultRDY=0 one cycle later.
REQ-029 SHALL: MULT 0x00010000 x 0x00010000 -> result 0x00000000, exception 1.
REQ-030 SHALL: DIV -7 / 2 -> result 0xFFFFFFFD, exception 0; DIV 0x80000000 / -1 -> result 0x80000000, exception 1.
REQ-031 SHALL: DIV 5 / 0 -> result 0, exception 1; RDY in the cycle after E0 with the macro defined, in the cycle after E32 without it.
REQ-032 SHALL: MULT 3 x 3 started, then at E10 DIV 100 / 7 -> exactly one RDY pulse, in the cycle after E10+32, with result 14; no RDY from the aborted multiply.
REQ-033 SHALL: reset pulsed during MULT_RUN at step 20 -> all outputs 0 immediately, no RDY; a following MULT 2 x 2 -> result 4.
